fp_div_8bit_seq: RTL and testbench
==================================

FP_DIV_8BIT_SEQ -- requirements
Module: fp_div_8bit_seq

Interface
REQ-001 The module SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request pulse; sampled only while busy=0.
REQ-005 flp_a  input  8  dividend: [7] sign, [6:4] exponent (bias 3), [3:0] fraction, implicit leading 1.
REQ-006 flp_b  input  8  divisor, same format as flp_a.
REQ-007 busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-008 done  output  1  single-cycle pulse; result and div_zero valid.
REQ-009 result  output  8  quotient, same format; held until the next done.
REQ-010 div_zero  output  1  set with done when flp_b[6:0]==0; held with result.

Function
REQ-011 Zero encoding SHALL be bits[6:0]==0; any other code SHALL be a normal value (-1)^s * 2^(e-3) * 1.f.
REQ-012 On the clock edge where start=1 and busy=0, operands SHALL be captured, busy SHALL go high, and the FSM SHALL leave IDLE.
REQ-013 start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-014 FSM states SHALL be IDLE -> DIV (N cycles) -> NORM (1 cycle) -> IDLE; done=1 is registered on the NORM edge.
REQ-015 In DIV, restoring division of 5-bit mantissas {1,fa} / {1,fb} SHALL produce one quotient bit per cycle, MSB first; an iteration counter SHALL select the bit.
REQ-016 N SHALL be 6 (1 integer + 5 fraction bits) without the configuration macro.
REQ-017 Latency SHALL be fixed at N+1 clocks from the start-sampling edge to the done-high cycle, for every operand value including special cases.
REQ-018 Sign SHALL be flp_a[7] XOR flp_b[7].
REQ-019 Exponent SHALL be computed signed, at least 5 bits wide: ea - eb + 3.
REQ-020 Normalization: if quotient MSB=0, shift the quotient left 1 and decrement the exponent by 1.
REQ-021 Fraction SHALL be the 4 bits following the leading 1, truncated.
REQ-022 If flp_b is zero: result={sign,111,0000} and div_zero=1; this takes precedence over a zero dividend.
REQ-023 Else if flp_a is zero: result=8'h00.
REQ-024 Else if exponent >7: result={sign,111,0000}, saturated.
REQ-025 Else if exponent <0: result=8'h00, underflow.
REQ-026 Else: result={sign,exp[2:0],frac}.
REQ-027 busy SHALL fall in the same cycle that done is high; a new start SHALL be accepted in that cycle.
REQ-028 result and div_zero SHALL change only on done edges or reset.

Reset
REQ-029 While rst=1 at a clock edge: FSM=IDLE, busy=0, done=0, result=8'h00, div_zero=0, and the counter and remainder are cleared.
REQ-030 Reset asserted mid-operation SHALL abort it with no done pulse; the first start after rst deasserts SHALL be processed normally.
REQ-031 rst SHALL take precedence over start on the same edge.

Configuration
REQ-032 Macro FP_DIV_ROUND_EN defined: N=7; the extra quotient bit is a guard bit, and round-half-up is applied to the 4-bit fraction.
REQ-033 With FP_DIV_ROUND_EN, fraction carry-out SHALL clear the fraction and increment the exponent before the overflow check; latency becomes 8.
REQ-034 Macro undefined: truncation per REQ-021; latency 7.

Verification
REQ-035 a=8'h48 (3.0), b=8'h38 (1.5), start -> done 7 clocks later; result=8'h40, div_zero=0.
REQ-036 a=8'h30, b=8'h33 -> result=8'h2A without FP_DIV_ROUND_EN and 8'h2B with it.
REQ-037 a=8'hC8, b=8'h38 -> result=8'hC0; a=8'h30, b=8'h00 -> result=8'h70, div_zero=1.
REQ-038 a=8'h70, b=8'h10 -> result=8'h70 (overflow); a=8'h10, b=8'h70 -> result=8'h00 (underflow).
REQ-039 Second start with different operands 2 cycles after the first -> ignored; only the first result appears, and busy is high throughout.
REQ-040 rst pulsed 3 cycles into an operation -> no done, busy=0, result=8'h00; the following start of 8'h48/8'h38 -> result=8'h40.

Source files
------------

// File: rtl/fp_div_8bit_seq.sv
// Sequential 8-bit float divider (1/3/4, bias 3): restoring mantissa division, one quotient bit per clock.
// Optional macro FP_DIV_ROUND_EN adds a guard bit with round-half-up; otherwise the fraction is truncated.
`timescale 1ns/1ps
module fp_div_8bit_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] flp_a,
  input  logic [7:0] flp_b,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       div_zero
);

`ifdef FP_DIV_ROUND_EN
  localparam int N = 7;
`else
  localparam int N = 6;
`endif
  localparam int CW = 3;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [5:0]        rem_q, rem_d;
  logic [4:0]        dvs_q, dvs_d;
  logic [N-1:0]      quo_q, quo_d;
  logic              sign_q, sign_d;
  logic signed [5:0] exp_q, exp_d;
  logic              az_q, az_d;
  logic              bz_q, bz_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        res_q, res_d;
  logic              dz_q, dz_d;

  // One restoring step: remainder never exceeds 2*divisor, so 6 bits suffice.
  logic          q_bit;
  logic [4:0]    rem_sub;
  logic [CW-1:0] bit_idx;

  always_comb begin
    q_bit   = (rem_q >= {1'b0, dvs_q});
    rem_sub = rem_q[4:0] - dvs_q;
    bit_idx = LAST - cnt_q;
  end

  // Normalization, optional rounding, and special-case priority.
  logic signed [5:0] exp_n;
  logic [3:0]        frac_n;
  logic [7:0]        res_calc;

  always_comb begin
    exp_n  = quo_q[N-1] ? exp_q : exp_q - 6'sd1;
    frac_n = quo_q[N-1] ? quo_q[N-2 -: 4] : quo_q[N-3 -: 4];
`ifdef FP_DIV_ROUND_EN
    if (quo_q[N-1] ? quo_q[N-6] : quo_q[N-7]) begin
      if (&frac_n) begin
        frac_n = 4'd0;
        exp_n  = exp_n + 6'sd1;
      end else begin
        frac_n = frac_n + 4'd1;
      end
    end
`endif
    if (bz_q)
      res_calc = {sign_q, 3'b111, 4'b0000};
    else if (az_q)
      res_calc = 8'h00;
    else if (exp_n > 6'sd7)
      res_calc = {sign_q, 3'b111, 4'b0000};
    else if (exp_n < 6'sd0)
      res_calc = 8'h00;
    else
      res_calc = {sign_q, exp_n[2:0], frac_n};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    az_d    = az_q;
    bz_d    = bz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          rem_d   = {2'b01, flp_a[3:0]};
          dvs_d   = {1'b1, flp_b[3:0]};
          quo_d   = '0;
          cnt_d   = '0;
          sign_d  = flp_a[7] ^ flp_b[7];
          exp_d   = $signed({3'b000, flp_a[6:4]}) - $signed({3'b000, flp_b[6:4]}) + 6'sd3;
          az_d    = (flp_a[6:0] == 7'd0);
          bz_d    = (flp_b[6:0] == 7'd0);
          busy_d  = 1'b1;
          state_d = DIV;
        end
      end
      DIV: begin
        quo_d[bit_idx] = q_bit;
        rem_d = q_bit ? {rem_sub, 1'b0} : {rem_q[4:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST)
          state_d = NORM;
      end
      NORM: begin
        res_d   = res_calc;
        dz_d    = bz_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      az_q    <= 1'b0;
      bz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= 8'h00;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      az_q    <= az_d;
      bz_q    <= bz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = res_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_fp_div_8bit_seq.sv
// Directed bench for fp_div_8bit_seq: scoreboard queue of expected results, popped on each done pulse.
`timescale 1ns/1ps
module tb_fp_div_8bit_seq;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] flp_a, flp_b;
  logic       busy, done, div_zero;
  logic [7:0] result;

  fp_div_8bit_seq dut (
    .clk(clk), .rst(rst), .start(start), .flp_a(flp_a), .flp_b(flp_b),
    .busy(busy), .done(done), .result(result), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

`ifdef FP_DIV_ROUND_EN
  localparam int LAT = 8;
  localparam logic [7:0] R_30_33 = 8'h2B;
`else
  localparam int LAT = 7;
  localparam logic [7:0] R_30_33 = 8'h2A;
`endif

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Leaves the bench at the negedge right after the start-sampling edge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic [7:0] res,
                        input logic dz, input bit now, input bit push);
    exp_t e;
    if (!now) @(negedge clk);
    flp_a = a;
    flp_b = b;
    start = 1'b1;
    e = {a, b, res, dz};
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles to done; optionally pulses a competing start at cycle 'inject'.
  task automatic wait_done(input int inject);
    int   cyc = 0;
    bit   seen = 0;
    bit   busy_ok = (busy === 1'b1);
    exp_t e;
    while (cyc < 20 && !seen) begin
      @(negedge clk);
      cyc++;
      if (inject > 0) begin
        start = (cyc == inject);
        if (cyc == inject) begin
          flp_a = 8'h70;
          flp_b = 8'h10;
        end
      end
      if (done === 1'b1) seen = 1;
      else if (busy !== 1'b1) busy_ok = 0;
    end
    start = 1'b0;
    chk("latency", 8'(cyc), 8'(LAT));
    if (seen) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_underflow: observed done with empty queue, expected pending entry");
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("result %h/%h", e.a, e.b), result, e.res);
        chk($sformatf("div_zero %h/%h", e.a, e.b), {7'd0, div_zero}, {7'd0, e.dz});
        $display("op a=%h b=%h -> result=%h div_zero=%b latency=%0d", e.a, e.b, result, div_zero, cyc);
      end
      chk("busy_at_done", {7'd0, busy}, 8'd0);
      chk("busy_while_running", {7'd0, busy_ok}, 8'd1);
    end
  endtask

  task automatic quiet(input int n, input string tag);
    int dn = 0;
    repeat (n) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    chk(tag, 8'(dn), 8'd0);
  endtask

  localparam int NT = 15;
  logic [7:0] ta [NT] = '{8'h48, 8'h30, 8'hC8, 8'h30, 8'h70, 8'h10, 8'h00, 8'h00,
                          8'hB8, 8'h3F, 8'h78, 8'h08, 8'h10, 8'h30, 8'h08};
  logic [7:0] tb [NT] = '{8'h38, 8'h33, 8'h38, 8'h00, 8'h10, 8'h70, 8'h38, 8'h80,
                          8'h48, 8'h30, 8'h30, 8'h30, 8'h48, 8'h38, 8'h40};
  logic [7:0] tr [NT] = '{8'h40, R_30_33, 8'hC0, 8'h70, 8'h70, 8'h00, 8'h00, 8'hF0,
                          8'hA0, 8'h3F, 8'h78, 8'h08, 8'h00, 8'h25, 8'h00};
  logic       tz [NT] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flp_a = 8'h00; flp_b = 8'h00;
    repeat (2) @(negedge clk);
    start = 1'b1; flp_a = 8'h48; flp_b = 8'h38;
    @(negedge clk);
    start = 1'b0;
    chk("reset_busy", {7'd0, busy}, 8'd0);
    chk("reset_done", {7'd0, done}, 8'd0);
    chk("reset_result", result, 8'h00);
    chk("reset_div_zero", {7'd0, div_zero}, 8'd0);
    rst = 1'b0;
    quiet(3, "no_done_after_reset");

    for (int i = 0; i < NT; i++) begin
      launch(ta[i], tb[i], tr[i], tz[i], 1'b0, 1'b1);
      wait_done(0);
    end

    chk("result_hold", result, 8'h00);
    quiet(3, "idle_no_done");
    chk("result_hold_later", result, 8'h00);

    // Back-to-back: new start accepted in the done cycle.
    launch(8'h3F, 8'h30, 8'h3F, 1'b0, 1'b0, 1'b1);
    wait_done(0);
    launch(8'h30, 8'h00, 8'h70, 1'b1, 1'b1, 1'b1);
    wait_done(0);

    // Competing start while busy must be ignored.
    launch(8'h48, 8'h38, 8'h40, 1'b0, 1'b0, 1'b1);
    wait_done(2);
    quiet(12, "ignored_start_no_done");

    // Reset mid-operation aborts without a done pulse.
    launch(8'h70, 8'h30, 8'h70, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_result", result, 8'h00);
    chk("abort_div_zero", {7'd0, div_zero}, 8'd0);
    quiet(12, "abort_no_done");
    launch(8'h48, 8'h38, 8'h40, 1'b0, 1'b0, 1'b1);
    wait_done(0);

    chk("scoreboard_empty", 8'(sb.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
